pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB).
//  Drives the enable (capture) and hold inputs of the if_id, id_ex, ex_mem and mem_wb latches.
//  Latch convention: ena=1 captures, ena=0 loads a zero bubble, hold=1 keeps contents (hold wins).
//  Resolves load-use hazards, taken branches, WB traps and multi-cycle EX ops (mul/div handshake).
// PARAMETERS
//  MC_TIMEOUT  64  max MC_WAIT cycles before abort (>=2)
//  REG_W       5   register-index width
//  CNT_W       32  width of performance counters (PERF_CNT_EN only)
// PORTS
//  clk           in   1      system clock, rising edge
//  rst_n         in   1      asynchronous reset, active low
//  id_rs1/id_rs2 in   REG_W  source regs of instruction in ID
//  id_use1/2     in   1      ID instruction actually reads rs1/rs2
//  ex_rd         in   REG_W  dest reg of instruction in EX
//  ex_is_load    in   1      EX instruction is a load
//  ex_is_mc      in   1      EX instruction is a multi-cycle op
//  ex_br_taken   in   1      EX branch/jump resolved taken (PC redirect is external)
//  wb_trap       in   1      trap/exception raised in WB
//  mc_done       in   1      multi-cycle unit result valid (1-cycle pulse)
//  mc_start      out  1      start pulse to multi-cycle unit
//  mc_abort      out  1      abort pulse to multi-cycle unit
//  mc_timeout    out  1      registered 1-cycle pulse: MC op exceeded MC_TIMEOUT
//  pc_hold       out  1      freeze PC
//  if_id_ena/if_id_hold, id_ex_ena/id_ex_hold  out 1 each
//  ex_mem_ena, mem_wb_ena    out 1 each (these latches have no hold)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=RUN, wait counter=0, mc_timeout=0; while rst_n=0 all ena/hold/pc_hold/mc_* = 0.
//  - Enables are combinational from inputs + state (act at next edge); only state/counter/mc_timeout are registered.
//  - Default (RUN, no event): all ena=1, all hold=0, pc_hold=0.
//  - Priority per cycle: trap/timeout > branch > multi-cycle > load-use.
//  - Trap (wb_trap=1, or mc_timeout=1): all four ena=0, holds=0, pc_hold=0; in MC_WAIT also mc_abort=1, ->RUN.
//  - Branch (ex_br_taken): if_id_ena=0, id_ex_ena=0, ex_mem_ena=1, mem_wb_ena=1, pc_hold=0.
//  - Load-use: ex_is_load & ex_rd!=0 & ((id_use1&id_rs1==ex_rd)|(id_use2&id_rs2==ex_rd)):
//    pc_hold=1, if_id_hold=1, id_ex_ena=0 (bubble), rest ena=1. Exactly 1 cycle; no state.
//  - FSM RUN->MC_WAIT: in RUN, ex_is_mc & no trap/branch: mc_start=1 (one cycle only), counter cleared.
//  - MC_WAIT (mc_done=0): pc_hold=1, if_id_hold=1, id_ex_hold=1, ex_mem_ena=0, mem_wb_ena=1; counter++.
//  - MC_WAIT & mc_done: ex_mem_ena=1, no holds, id_ex captures next instr, ->RUN; no re-trigger in that cycle.
//  - Timeout: counter==MC_TIMEOUT-1 & !mc_done -> mc_timeout=1 next cycle, handled as trap.
//    mc_done in the terminal cycle wins (no timeout). mc_done in RUN is ignored.
//  - Load-use is not evaluated in MC_WAIT (ID already held).
//  - Counter saturates; never wraps.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined: adds outputs stall_cnt[CNT_W-1:0] and flush_cnt[CNT_W-1:0], reset 0.
//    stall_cnt: +1 per cycle with pc_hold=1. flush_cnt: +1 per trap or branch event.
//    Both wrap modulo 2^CNT_W.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  - Reset: rst_n low mid-MC_WAIT -> all outputs 0 immediately; after release state RUN, ena all 1.
//  - Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_use1=1 -> pc_hold=1, if_id_hold=1, id_ex_ena=0 for exactly 1 cycle.
//    Same with ex_rd=0 -> no stall.
//  - Multi-cycle: ex_is_mc=1, mc_done after 10 cycles -> mc_start 1 cycle; holds 10 cycles; ex_mem_ena=1 on done; RUN.
//  - Timeout: MC_TIMEOUT=8, no mc_done -> mc_timeout pulse after 8 MC_WAIT cycles, all ena=0, mc_abort=1;
//    mc_done on cycle 8 -> no timeout.
//  - Priority: wb_trap=1 with ex_br_taken=1 and load-use -> trap response only; branch + load-use -> branch response only.
//  - PIPE_PERF_CNT_EN: 3 load-use stalls + 10-cycle MC op -> stall_cnt=13; 2 branches + 1 trap -> flush_cnt=3.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//    Stall/flush sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB). It drives
//    the capture enables and hold controls of the if_id, id_ex, ex_mem and mem_wb
//    latches, and it freezes the PC.
//    Latch behaviour: ena=1 captures, ena=0 loads a bubble, hold=1 keeps the
//    contents (hold wins over ena).
//    Sources of hazards: load-use, taken branch, WB trap, and multi-cycle EX ops
//    that use a start/done handshake with a watchdog timeout.
//
//    Optional feature: define PIPE_PERF_CNT_EN to add the stall_cnt and
//    flush_cnt performance counters.
//
// Ports
//    clk, rst_n              clock (rising edge), async reset (active low)
//    id_rs1/id_rs2           source registers of the instruction in ID
//    id_use1/id_use2         the ID instruction really reads rs1/rs2
//    ex_rd                   destination register of the instruction in EX
//    ex_is_load/ex_is_mc     the EX instruction is a load / a multi-cycle op
//    ex_br_taken             the EX branch resolved taken
//    wb_trap                 trap raised in WB
//    mc_done                 multi-cycle result valid (1-cycle pulse)
//    mc_start/mc_abort       pulses to the multi-cycle unit
//    mc_timeout              registered pulse: the multi-cycle op overran
//    pc_hold                 freeze the PC
//    *_ena / *_hold          pipeline latch controls
//    stall_cnt/flush_cnt     performance counters (PIPE_PERF_CNT_EN only)
//
// state   | meaning
// --------+-------------------------------------------------------------
// RUN     | normal flow; load-use, branch and trap are handled combinationally
// MC_WAIT | multi-cycle op in EX; front end held until mc_done, trap or timeout

module pipeline_hazard_ctrl #(
   parameter int MC_TIMEOUT = 64,
   parameter int REG_W      = 5
`ifdef PIPE_PERF_CNT_EN
   ,
   parameter int CNT_W      = 32
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_use1,
   input  logic             id_use2,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_is_load,
   input  logic             ex_is_mc,
   input  logic             ex_br_taken,
   input  logic             wb_trap,
   input  logic             mc_done,
   output logic             mc_start,
   output logic             mc_abort,
   output logic             mc_timeout,
   output logic             pc_hold,
   output logic             if_id_ena,
   output logic             if_id_hold,
   output logic             id_ex_ena,
   output logic             id_ex_hold,
   output logic             ex_mem_ena,
   output logic             mem_wb_ena
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);

   localparam logic [0:0] ST_RUN     = 1'b0;
   localparam logic [0:0] ST_MC_WAIT = 1'b1;

   localparam int            CW       = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_TERM = CW'(MC_TIMEOUT - 1);

   logic [0:0]    state, state_nxt;
   logic [CW-1:0] wait_cnt, wait_cnt_nxt;
   logic          timeout_nxt;
   logic          trap, load_use;

   logic mc_start_c, mc_abort_c, pc_hold_c;
   logic if_id_ena_c, if_id_hold_c, id_ex_ena_c, id_ex_hold_c, ex_mem_ena_c, mem_wb_ena_c;

   // A pending timeout is handled the same way as a trap in the cycle it shows.
   assign trap = wb_trap | mc_timeout;

   assign load_use = ex_is_load && (ex_rd != '0) &&
                     ((id_use1 && (id_rs1 == ex_rd)) || (id_use2 && (id_rs2 == ex_rd)));

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      timeout_nxt  = 1'b0;
      mc_start_c   = 1'b0;
      mc_abort_c   = 1'b0;
      if (state == ST_RUN) begin
         if (ex_is_mc && !trap && !ex_br_taken) begin
            mc_start_c   = 1'b1;
            state_nxt    = ST_MC_WAIT;
            wait_cnt_nxt = '0;
         end
      end else begin
         if (trap) begin
            mc_abort_c = 1'b1;
            state_nxt  = ST_RUN;
         end else if (mc_done) begin
            state_nxt = ST_RUN;
         end else if (wait_cnt == CNT_TERM) begin
            // The counter sits at the terminal value; the pulse aborts the op next cycle.
            timeout_nxt = 1'b1;
         end else begin
            wait_cnt_nxt = wait_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      pc_hold_c    = 1'b0;
      if_id_ena_c  = 1'b1;
      if_id_hold_c = 1'b0;
      id_ex_ena_c  = 1'b1;
      id_ex_hold_c = 1'b0;
      ex_mem_ena_c = 1'b1;
      mem_wb_ena_c = 1'b1;
      if (trap) begin
         if_id_ena_c  = 1'b0;
         id_ex_ena_c  = 1'b0;
         ex_mem_ena_c = 1'b0;
         mem_wb_ena_c = 1'b0;
      end else if (ex_br_taken) begin
         if_id_ena_c = 1'b0;
         id_ex_ena_c = 1'b0;
      end else if (mc_start_c || (state == ST_MC_WAIT && !mc_done)) begin
         // Keep the multi-cycle op parked in EX; MEM/WB keep draining.
         pc_hold_c    = 1'b1;
         if_id_hold_c = 1'b1;
         id_ex_hold_c = 1'b1;
         ex_mem_ena_c = 1'b0;
      end else if (state == ST_RUN && load_use) begin
         pc_hold_c    = 1'b1;
         if_id_hold_c = 1'b1;
         id_ex_ena_c  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_RUN;
         wait_cnt   <= '0;
         mc_timeout <= 1'b0;
      end else begin
         state      <= state_nxt;
         wait_cnt   <= wait_cnt_nxt;
         mc_timeout <= timeout_nxt;
      end
   end

   // Every control is forced low while reset is asserted, independent of the clock.
   assign mc_start   = rst_n & mc_start_c;
   assign mc_abort   = rst_n & mc_abort_c;
   assign pc_hold    = rst_n & pc_hold_c;
   assign if_id_ena  = rst_n & if_id_ena_c;
   assign if_id_hold = rst_n & if_id_hold_c;
   assign id_ex_ena  = rst_n & id_ex_ena_c;
   assign id_ex_hold = rst_n & id_ex_hold_c;
   assign ex_mem_ena = rst_n & ex_mem_ena_c;
   assign mem_wb_ena = rst_n & mem_wb_ena_c;

`ifdef PIPE_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         stall_cnt <= stall_cnt + CNT_W'(pc_hold_c);
         flush_cnt <= flush_cnt + CNT_W'(trap | ex_br_taken);
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl. Two instances share the stimulus: dut_a uses
// MC_TIMEOUT=64 and dut_b uses MC_TIMEOUT=8. mc_sel steers ex_is_mc to only one
// of them, so a long multi-cycle op and a timeout can each be exercised.
// Output vector bit order: {mc_start, mc_abort, mc_timeout, pc_hold, if_id_ena,
// if_id_hold, id_ex_ena, id_ex_hold, ex_mem_ena, mem_wb_ena}.

module tb_pipeline_hazard_ctrl;

   localparam logic [9:0] V_RUN = 10'b0000101011;
   localparam logic [9:0] V_LU  = 10'b0001110011;
   localparam logic [9:0] V_BR  = 10'b0000000011;
   localparam logic [9:0] V_TRP = 10'b0000000000;
   localparam logic [9:0] V_ABT = 10'b0100000000;
   localparam logic [9:0] V_TO  = 10'b0110000000;
   localparam logic [9:0] V_MCS = 10'b1001111101;
   localparam logic [9:0] V_MCW = 10'b0001111101;
   localparam logic [9:0] V_RST = 10'b0000000000;

   // stimulus flags {use1, use2, load, mc, br, trap, done}
   localparam logic [6:0] F_U1 = 7'b1000000;
   localparam logic [6:0] F_U2 = 7'b0100000;
   localparam logic [6:0] F_LD = 7'b0010000;
   localparam logic [6:0] F_MC = 7'b0001000;
   localparam logic [6:0] F_BR = 7'b0000100;
   localparam logic [6:0] F_TR = 7'b0000010;
   localparam logic [6:0] F_DN = 7'b0000001;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_use1, id_use2, ex_is_load, ex_is_mc, ex_br_taken, wb_trap, mc_done;
   logic       mc_sel;
   logic       mc_a, mc_b;
   assign mc_a = ex_is_mc & ~mc_sel;
   assign mc_b = ex_is_mc & mc_sel;

   logic a_start, a_abort, a_to, a_pch, a_ifena, a_ifhold, a_idena, a_idhold, a_exena, a_mwena;
   logic b_start, b_abort, b_to, b_pch, b_ifena, b_ifhold, b_idena, b_idhold, b_exena, b_mwena;
`ifdef PIPE_PERF_CNT_EN
   logic [31:0] a_stall, a_flush, b_stall, b_flush;
`endif

   pipeline_hazard_ctrl #(.MC_TIMEOUT(64), .REG_W(5)) dut_a (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use1(id_use1), .id_use2(id_use2), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
      .ex_is_mc(mc_a), .ex_br_taken(ex_br_taken), .wb_trap(wb_trap), .mc_done(mc_done),
      .mc_start(a_start), .mc_abort(a_abort), .mc_timeout(a_to), .pc_hold(a_pch),
      .if_id_ena(a_ifena), .if_id_hold(a_ifhold), .id_ex_ena(a_idena), .id_ex_hold(a_idhold),
      .ex_mem_ena(a_exena), .mem_wb_ena(a_mwena)
`ifdef PIPE_PERF_CNT_EN
      , .stall_cnt(a_stall), .flush_cnt(a_flush)
`endif
   );

   pipeline_hazard_ctrl #(.MC_TIMEOUT(8), .REG_W(5)) dut_b (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use1(id_use1), .id_use2(id_use2), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
      .ex_is_mc(mc_b), .ex_br_taken(ex_br_taken), .wb_trap(wb_trap), .mc_done(mc_done),
      .mc_start(b_start), .mc_abort(b_abort), .mc_timeout(b_to), .pc_hold(b_pch),
      .if_id_ena(b_ifena), .if_id_hold(b_ifhold), .id_ex_ena(b_idena), .id_ex_hold(b_idhold),
      .ex_mem_ena(b_exena), .mem_wb_ena(b_mwena)
`ifdef PIPE_PERF_CNT_EN
      , .stall_cnt(b_stall), .flush_cnt(b_flush)
`endif
   );

   logic [9:0] out_a, out_b;
   assign out_a = {a_start, a_abort, a_to, a_pch, a_ifena, a_ifhold, a_idena, a_idhold, a_exena, a_mwena};
   assign out_b = {b_start, b_abort, b_to, b_pch, b_ifena, b_ifhold, b_idena, b_idhold, b_exena, b_mwena};

   logic [9:0] exp_a_q[$];
   logic [9:0] exp_b_q[$];
   string      name_q[$];
   int         n_cmp  = 0;
   int         n_fail = 0;

   task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [6:0] f, input logic [9:0] ea, input logic [9:0] eb,
                       input string nm);
      @(posedge clk);
      #1;
      id_rs1      = rs1;
      id_rs2      = rs2;
      ex_rd       = rd;
      id_use1     = f[6];
      id_use2     = f[5];
      ex_is_load  = f[4];
      ex_is_mc    = f[3];
      ex_br_taken = f[2];
      wb_trap     = f[1];
      mc_done     = f[0];
      exp_a_q.push_back(ea);
      exp_b_q.push_back(eb);
      name_q.push_back(nm);
   endtask

   task automatic idle(input logic [9:0] ea, input logic [9:0] eb, input string nm);
      step(5'd0, 5'd0, 5'd0, 7'b0, ea, eb, nm);
   endtask

   // monitor / scoreboard
   initial begin
      logic [9:0] ea, eb;
      string      nm;
      forever begin
         @(negedge clk);
         if (exp_a_q.size() > 0) begin
            ea = exp_a_q.pop_front();
            eb = exp_b_q.pop_front();
            nm = name_q.pop_front();
            n_cmp++;
            if (out_a !== ea) begin
               n_fail++;
               $display("FAIL %s dut_a: got %b expected %b", nm, out_a, ea);
            end
            n_cmp++;
            if (out_b !== eb) begin
               n_fail++;
               $display("FAIL %s dut_b: got %b expected %b", nm, out_b, eb);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      mc_sel = 1'b0;
      id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
      id_use1 = 0; id_use2 = 0; ex_is_load = 0; ex_is_mc = 0;
      ex_br_taken = 0; wb_trap = 0; mc_done = 0;

      idle(V_RST, V_RST, "reset_hold");
      idle(V_RST, V_RST, "reset_hold");
      @(negedge clk); #1; rst_n = 1'b1;
      idle(V_RUN, V_RUN, "after_reset");

      // load-use
      step(5'd5, 5'd0, 5'd5, F_U1 | F_LD, V_LU, V_LU, "lu_rs1");
      idle(V_RUN, V_RUN, "lu_one_cycle");
      step(5'd0, 5'd7, 5'd7, F_U2 | F_LD, V_LU, V_LU, "lu_rs2");
      step(5'd0, 5'd0, 5'd0, F_U1 | F_LD, V_RUN, V_RUN, "lu_rd0");
      step(5'd5, 5'd0, 5'd5, F_LD, V_RUN, V_RUN, "lu_no_use");
      step(5'd5, 5'd0, 5'd5, F_U1, V_RUN, V_RUN, "lu_not_load");
      step(5'd3, 5'd0, 5'd5, F_U1 | F_LD, V_RUN, V_RUN, "lu_reg_differs");

      // branch, trap and priority
      step(5'd0, 5'd0, 5'd0, F_BR, V_BR, V_BR, "branch");
      step(5'd5, 5'd0, 5'd5, F_U1 | F_LD | F_BR, V_BR, V_BR, "br_over_lu");
      step(5'd5, 5'd0, 5'd5, F_U1 | F_LD | F_BR | F_TR, V_TRP, V_TRP, "trap_over_all");
      step(5'd0, 5'd0, 5'd0, F_MC | F_TR, V_TRP, V_TRP, "trap_blocks_mc");
      idle(V_RUN, V_RUN, "no_mc_after_trap");
      step(5'd0, 5'd0, 5'd0, F_MC | F_BR, V_BR, V_BR, "br_blocks_mc");
      idle(V_RUN, V_RUN, "no_mc_after_br");
      step(5'd0, 5'd0, 5'd0, F_DN, V_RUN, V_RUN, "done_in_run_ignored");

      // 10-cycle multi-cycle op on dut_a
      step(5'd0, 5'd0, 5'd0, F_MC, V_MCS, V_RUN, "mc_start");
      repeat (9) step(5'd0, 5'd0, 5'd0, F_MC, V_MCW, V_RUN, "mc_wait");
      step(5'd0, 5'd0, 5'd0, F_MC | F_DN, V_RUN, V_RUN, "mc_done");
      idle(V_RUN, V_RUN, "mc_back_to_run");

      // load-use not evaluated while waiting (dut_b in RUN still stalls)
      step(5'd5, 5'd0, 5'd5, F_MC | F_U1 | F_LD, V_MCS, V_LU, "mc_start_over_lu");
      step(5'd5, 5'd0, 5'd5, F_MC | F_U1 | F_LD, V_MCW, V_LU, "lu_ignored_in_wait");
      step(5'd0, 5'd0, 5'd0, F_MC | F_DN, V_RUN, V_RUN, "mc_done_2");
      idle(V_RUN, V_RUN, "mc_back_to_run_2");

      // timeout on dut_b (MC_TIMEOUT=8)
      mc_sel = 1'b1;
      step(5'd0, 5'd0, 5'd0, F_MC, V_RUN, V_MCS, "to_start");
      repeat (8) step(5'd0, 5'd0, 5'd0, F_MC, V_RUN, V_MCW, "to_wait");
      step(5'd0, 5'd0, 5'd0, F_MC, V_RUN, V_TO, "timeout");
      idle(V_RUN, V_RUN, "timeout_pulse_end");

      // mc_done in the terminal cycle wins
      step(5'd0, 5'd0, 5'd0, F_MC, V_RUN, V_MCS, "term_start");
      repeat (7) step(5'd0, 5'd0, 5'd0, F_MC, V_RUN, V_MCW, "term_wait");
      step(5'd0, 5'd0, 5'd0, F_MC | F_DN, V_RUN, V_RUN, "done_terminal");
      idle(V_RUN, V_RUN, "no_late_timeout");

      // trap while waiting aborts
      step(5'd0, 5'd0, 5'd0, F_MC, V_RUN, V_MCS, "abort_start");
      repeat (2) step(5'd0, 5'd0, 5'd0, F_MC, V_RUN, V_MCW, "abort_wait");
      step(5'd0, 5'd0, 5'd0, F_MC | F_TR, V_TRP, V_ABT, "trap_abort");
      idle(V_RUN, V_RUN, "after_abort");

      // async reset in the middle of MC_WAIT
      mc_sel = 1'b0;
      step(5'd0, 5'd0, 5'd0, F_MC, V_MCS, V_RUN, "rst_mc_start");
      repeat (3) step(5'd0, 5'd0, 5'd0, F_MC, V_MCW, V_RUN, "rst_mc_wait");
      step(5'd0, 5'd0, 5'd0, F_MC, V_RST, V_RST, "reset_async");
      rst_n = 1'b0;
      idle(V_RST, V_RST, "reset_async_hold");
      @(negedge clk); #1; rst_n = 1'b1;
      idle(V_RUN, V_RUN, "release_run");

`ifdef PIPE_PERF_CNT_EN
      @(negedge clk); #1; rst_n = 1'b0;
      @(negedge clk); #1; rst_n = 1'b1;
      mc_sel = 1'b0;
      repeat (3) begin
         step(5'd5, 5'd0, 5'd5, F_U1 | F_LD, V_LU, V_LU, "perf_lu");
         idle(V_RUN, V_RUN, "perf_idle");
      end
      step(5'd0, 5'd0, 5'd0, F_MC, V_MCS, V_RUN, "perf_mc_start");
      repeat (9) step(5'd0, 5'd0, 5'd0, F_MC, V_MCW, V_RUN, "perf_mc_wait");
      step(5'd0, 5'd0, 5'd0, F_MC | F_DN, V_RUN, V_RUN, "perf_mc_done");
      step(5'd0, 5'd0, 5'd0, F_BR, V_BR, V_BR, "perf_br");
      idle(V_RUN, V_RUN, "perf_idle");
      step(5'd0, 5'd0, 5'd0, F_BR, V_BR, V_BR, "perf_br");
      step(5'd0, 5'd0, 5'd0, F_TR, V_TRP, V_TRP, "perf_trap");
      idle(V_RUN, V_RUN, "perf_idle");
      @(posedge clk); #1;
      n_cmp++;
      if (a_stall !== 32'd13) begin
         n_fail++; $display("FAIL stall_cnt_a: got %0d expected 13", a_stall);
      end
      n_cmp++;
      if (b_stall !== 32'd3) begin
         n_fail++; $display("FAIL stall_cnt_b: got %0d expected 3", b_stall);
      end
      n_cmp++;
      if (a_flush !== 32'd3) begin
         n_fail++; $display("FAIL flush_cnt_a: got %0d expected 3", a_flush);
      end
      n_cmp++;
      if (b_flush !== 32'd3) begin
         n_fail++; $display("FAIL flush_cnt_b: got %0d expected 3", b_flush);
      end
`endif

      repeat (3) @(negedge clk);
      #1;
      n_cmp++;
      if (exp_a_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_a_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
